uart_tx_seq: RTL and testbench

- Downstream consumer of the byte-splitting stage; serialises each demodulated sample onto the UART line as a burst of bytes.
- On a sample-ready pulse, reads the current byte from the splitter and transmits it as a UART frame: 8N1, LSB first.
- Pulses the splitter's byte-advance input after each byte is latched, then repeats until BYTES_PER_FRAME bytes have been sent.
- Includes its own baud-tick counter, with no external baud generator.

---
 rtl/uart_tx_seq.sv | 146 ++++++++++++++
 tb/tb_uart_tx_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_seq.sv
// Burst UART transmitter: on each sample-ready pulse, sends BYTES_PER_FRAME bytes from the splitter as 8N1 frames.
// Optional UART_TX_PARITY_EN inserts an even-parity bit per byte (8E1).
module uart_tx_seq #(
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned BYTES_PER_FRAME = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       merge_finished_i,
    input  logic [7:0] data_uart_i,
    output logic       tx_o,
    output logic       next_byte_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       overrun_o
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(BYTES_PER_FRAME) + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [CW-1:0] byte_cnt, byte_cnt_n, byte_cnt_inc;
    logic [7:0]    shift_reg, shift_n;
    logic          tx_n, next_byte_n, busy_n, done_n, overrun_n;
    logic          bit_end;

    assign bit_end      = (timer == TW'(CLKS_PER_BIT - 1));
    assign byte_cnt_inc = byte_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            byte_cnt     <= '0;
            shift_reg    <= '0;
            tx_o         <= 1'b1;
            next_byte_o  <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            bit_idx      <= bit_idx_n;
            byte_cnt     <= byte_cnt_n;
            shift_reg    <= shift_n;
            tx_o         <= tx_n;
            next_byte_o  <= next_byte_n;
            busy_o       <= busy_n;
            frame_done_o <= done_n;
            overrun_o    <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = bit_end ? '0 : timer + TW'(1);
        bit_idx_n   = bit_idx;
        byte_cnt_n  = byte_cnt;
        shift_n     = shift_reg;
        tx_n        = tx_o;
        next_byte_n = 1'b0;
        busy_n      = busy_o;
        done_n      = 1'b0;
        // The done cycle still counts as busy: a pulse there is an overrun, not a new burst.
        overrun_n   = overrun_o | (merge_finished_i & (busy_o | frame_done_o));

        case (state)
            IDLE: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                timer_n = '0;
                if (merge_finished_i && !frame_done_o) begin
                    state_n    = LOAD;
                    byte_cnt_n = '0;
                    busy_n     = 1'b1;
                end
            end
            LOAD: begin
                // Splitter buffer was loaded one edge ago, so its byte is valid now.
                shift_n     = data_uart_i;
                next_byte_n = 1'b1;
                tx_n        = 1'b0;
                timer_n     = '0;
                state_n     = START;
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^shift_reg;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift_reg[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    byte_cnt_n = byte_cnt_inc;
                    tx_n       = 1'b1;
                    if (byte_cnt_inc < CW'(BYTES_PER_FRAME)) begin
                        state_n = LOAD;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: behavioural splitter stub upstream, expected line waveform built from frame rules.
module tb_uart_tx_seq;
    localparam int C = 4;
    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int BL = F * C + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        merge = 1'b0;
    logic [15:0] data_i = '0;
    logic [7:0]  data_uart;
    logic        tx, next_byte, busy, done, ovr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Splitter stub: 32-bit buffer {16'h0, sample}, high byte first, 2-bit index advanced by start_i.
    logic [31:0] sbuf = '0;
    logic [1:0]  sidx = '0;
    always_ff @(posedge clk) begin
        if (rst) sidx <= '0;
        else begin
            if (merge) sbuf <= {16'h0, data_i};
            if (next_byte) sidx <= sidx + 2'd1;
        end
    end
    assign data_uart = sbuf[31 - 8*sidx -: 8];

    uart_tx_seq #(.CLKS_PER_BIT(C), .BYTES_PER_FRAME(N)) dut (
        .clk(clk), .rst(rst), .merge_finished_i(merge), .data_uart_i(data_uart),
        .tx_o(tx), .next_byte_o(next_byte), .busy_o(busy), .frame_done_o(done), .overrun_o(ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic even_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return logic'(ones % 2);
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] d, input int b);
        logic [31:0] w;
        w = {16'h0, d};
        return w[31 - 8*b -: 8];
    endfunction

    // Expected line level k cycles after the edge that accepts the pulse.
    function automatic logic exp_tx(input logic [15:0] d, input int k);
        int b, o, fb;
        logic [7:0] by;
        b  = k / BL;
        o  = k % BL;
        by = byte_of(d, b);
        if (o == 0) return 1'b1;
        fb = (o - 1) / C;
        if (fb == 0) return 1'b0;
        if (fb <= 8) return by[fb-1];
        if (F == 11 && fb == 9) return even_par(by);
        return 1'b1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_nxt", next_byte, 0);
            chk("idle_done", done, 0);
        end
    endtask

    // Called at a negedge; returns at the negedge where frame_done is expected high.
    task automatic send(input logic [15:0] d, input int ovr_at, input logic ovr_exp);
        logic       obs [N*BL];
        logic [7:0] got;
        int         nb = 0;
        data_i = d;
        merge  = 1'b1;
        cyc();
        merge  = 1'b0;
        for (int k = 0; k < N*BL; k++) begin
            if (k > 0) cyc();
            merge  = (k == ovr_at);
            obs[k] = tx;
            chk("tx", tx, exp_tx(d, k));
            chk("busy", busy, 1);
            chk("nxt", next_byte, (k % BL) == 1);
            chk("done_early", done, 0);
            nb += int'(next_byte);
        end
        merge = 1'b0;
        cyc();
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("tx_end", tx, 1);
        chk("nxt_count", nb, N);
        chk("overrun", ovr, ovr_exp);
        for (int b = 0; b < N; b++) begin
            chk("start_bit", obs[b*BL + 1 + C/2], 0);
            for (int i = 0; i < 8; i++) got[i] = obs[b*BL + 1 + (1+i)*C + C/2];
            chk("byte", got, byte_of(d, b));
        end
    endtask

    initial begin
        logic [15:0] r;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_nxt", next_byte, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        idle(50);

        // Single sample, then the bit-timing pattern.
        send(16'h1234, -1, 0);
        idle(3);
        send(16'h00A5, -1, 0);
        idle(3);

        // Back-to-back: second pulse one cycle after frame_done.
        send(16'hBEEF, -1, 0);
        cyc();
        chk("b2b_done_low", done, 0);
        send(16'h0102, -1, 0);
        idle(2);

        for (int n = 0; n < 4; n++) begin
            r = 16'($urandom_range(0, 65535));
            send(r, -1, 0);
            idle(int'($urandom_range(1, 5)));
        end

        // Pulse coincident with frame_done is an overrun and starts nothing.
        r = 16'($urandom_range(0, 65535));
        send(r, -1, 0);
        merge = 1'b1;
        cyc();
        merge = 1'b0;
        chk("done_edge_ovr", ovr, 1);
        idle(20);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("ovr_cleared", ovr, 0);

        // Overrun mid-burst: burst unaffected, no second burst, flag sticky.
        send(16'h1234, 20, 1);
        idle(60);
        chk("ovr_sticky", ovr, 1);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle(2);

        // Reset during DATA of byte index 2.
        data_i = 16'hC3A7;
        merge  = 1'b1;
        cyc();
        merge  = 1'b0;
        repeat (2*BL + 1 + C + 5) cyc();
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_nxt", next_byte, 0);
        rst = 1'b0;
        idle(10);
        send(16'h5A3C, -1, 0);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
